video_timing_gen: RTL and testbench

Parametrised raster timing generator and the successor to the fixed 640x480 VGA controller. It produces H/V sync with configurable polarity, blanking, and screen coordinates from programmable porch/sync/active parameters, with all outputs registered and mutually aligned. It adds line/frame/vblank event pulses and an integer-scaled viewport window, default 160x144 at 3x centred, that yields source-pixel coordinates for the Game Boy framebuffer read path. It sits between the PPU framebuffer reader and the HDMI encoder.

---
 rtl/video_timing_pkg.sv | 26 ++
 rtl/video_timing_gen_scale_counter.sv | 48 ++++
 rtl/video_timing_gen.sv | 154 +++++++++++++++
 tb/tb_video_timing_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | video_timing_pkg : default 640x480@60 raster timings, GB geometry  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package video_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int GB_W = 160;
  localparam int GB_H = 144;

  function automatic int timing_total(input int active, input int fp,
                                      input int sync_len, input int bp);
    return active + fp + sync_len + bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_gen_scale_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | scale_counter : divider-free source coordinate for a scaled window |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module scale_counter
  import video_timing_pkg::*;
#(
  parameter int LIMIT = GB_W,
  parameter int SCALE = 3,
  localparam int CXW  = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic           pixel_clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           step,
  input  logic           in_range,
  output logic [CXW-1:0] coord
);

  localparam int SXW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SXW-1:0] c_sx_last = SXW'(SCALE - 1);

  logic [SXW-1:0] r_sx;
  logic [CXW-1:0] r_cx;

  // State describes the current position; a step moves it to the next one.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sx <= '0;
      r_cx <= '0;
    end else if (step) begin
      if (start || !in_range) begin
        r_sx <= '0;
        r_cx <= '0;
      end else if (r_sx == c_sx_last) begin
        r_sx <= '0;
        r_cx <= r_cx + CXW'(1);
      end else begin
        r_sx <= r_sx + SXW'(1);
      end
    end
  end

  assign coord = in_range ? r_cx : '0;

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | video_timing_gen : registered raster timing with scaled viewport    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int VP_X0    = 80,
  parameter int VP_Y0    = 24,
  parameter int VP_W     = GB_W,
  parameter int VP_H     = GB_H,
  parameter int SCALE    = 3,
  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int CW      = $clog2(H_TOTAL),
  localparam int RW      = $clog2(V_TOTAL),
  localparam int XW      = (VP_W > 1) ? $clog2(VP_W) : 1,
  localparam int YW      = (VP_H > 1) ? $clog2(VP_H) : 1
) (
  input  logic          pixel_clk,
  input  logic          reset_n,
  output logic          hs,
  output logic          vs,
  output logic          active_nblank,
  output logic          sync,
  output logic [CW-1:0] drawX,
  output logic [RW-1:0] drawY,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_start,
  output logic          vp_active,
  output logic [XW-1:0] vp_x,
  output logic [YW-1:0] vp_y
);

  if (SCALE < 1) begin : g_chk_scale
    $error("video_timing_gen: SCALE must be at least 1");
  end
  if (VP_X0 + VP_W * SCALE > H_ACTIVE) begin : g_chk_vp_x
    $error("video_timing_gen: viewport exceeds H_ACTIVE");
  end
  if (VP_Y0 + VP_H * SCALE > V_ACTIVE) begin : g_chk_vp_y
    $error("video_timing_gen: viewport exceeds V_ACTIVE");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_chk_porch
    $error("video_timing_gen: porch and sync lengths must be non-zero");
  end

  localparam logic [CW-1:0] c_h_last    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] c_h_act     = CW'(H_ACTIVE);
  localparam logic [CW-1:0] c_hs_beg    = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] c_hs_len    = CW'(H_SYNC);
  localparam logic [CW-1:0] c_vpx_beg   = CW'(VP_X0);
  localparam logic [CW-1:0] c_vpx_len   = CW'(VP_W * SCALE);
  localparam logic [RW-1:0] c_v_last    = RW'(V_TOTAL - 1);
  localparam logic [RW-1:0] c_v_act     = RW'(V_ACTIVE);
  localparam logic [RW-1:0] c_vs_beg    = RW'(V_ACTIVE + V_FP);
  localparam logic [RW-1:0] c_vs_len    = RW'(V_SYNC);
  localparam logic [RW-1:0] c_vpy_beg   = RW'(VP_Y0);
  localparam logic [RW-1:0] c_vpy_len   = RW'(VP_H * SCALE);

  logic [CW-1:0] r_hc, w_hc_next, w_hs_off, w_vpx_off;
  logic [RW-1:0] r_vc, w_vc_next, w_vs_off, w_vpy_off;
  logic          w_h_last, w_v_last, w_hs_in, w_vs_in, w_x_in, w_y_in;
  logic [XW-1:0] w_x_coord;
  logic [YW-1:0] w_y_coord;

  assign w_h_last  = (r_hc == c_h_last);
  assign w_v_last  = (r_vc == c_v_last);
  assign w_hc_next = w_h_last ? '0 : r_hc + CW'(1);
  assign w_vc_next = !w_h_last ? r_vc : (w_v_last ? '0 : r_vc + RW'(1));

  // Offset-and-compare windows: values below the start wrap to large numbers.
  assign w_hs_off  = r_hc - c_hs_beg;
  assign w_vs_off  = r_vc - c_vs_beg;
  assign w_vpx_off = r_hc - c_vpx_beg;
  assign w_vpy_off = r_vc - c_vpy_beg;
  assign w_hs_in   = (w_hs_off < c_hs_len);
  assign w_vs_in   = (w_vs_off < c_vs_len);
  assign w_x_in    = (w_vpx_off < c_vpx_len);
  assign w_y_in    = (w_vpy_off < c_vpy_len);

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hc <= '0;
      r_vc <= '0;
    end else begin
      r_hc <= w_hc_next;
      r_vc <= w_vc_next;
    end
  end

  scale_counter #(.LIMIT(VP_W), .SCALE(SCALE)) u_scale_x (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .start     (w_hc_next == c_vpx_beg),
    .step      (1'b1),
    .in_range  (w_x_in),
    .coord     (w_x_coord)
  );

  scale_counter #(.LIMIT(VP_H), .SCALE(SCALE)) u_scale_y (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .start     (w_h_last && (w_vc_next == c_vpy_beg)),
    .step      (w_h_last),
    .in_range  (w_y_in),
    .coord     (w_y_coord)
  );

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs            <= ~HS_POL;
      vs            <= ~VS_POL;
      active_nblank <= 1'b0;
      drawX         <= '0;
      drawY         <= '0;
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
      vblank_start  <= 1'b0;
      vp_active     <= 1'b0;
      vp_x          <= '0;
      vp_y          <= '0;
    end else begin
      hs            <= w_hs_in ? HS_POL : ~HS_POL;
      vs            <= w_vs_in ? VS_POL : ~VS_POL;
      active_nblank <= (r_hc < c_h_act) && (r_vc < c_v_act);
      drawX         <= r_hc;
      drawY         <= r_vc;
      line_start    <= (r_hc == '0);
      frame_start   <= (r_hc == '0) && (r_vc == '0);
      vblank_start  <= (r_hc == '0) && (r_vc == c_v_act);
      vp_active     <= w_x_in && w_y_in;
      vp_x          <= (w_x_in && w_y_in) ? w_x_coord : '0;
      vp_y          <= w_y_coord;
    end
  end

  assign sync = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_video_timing_gen : directed checks on default, alternate, small  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_video_timing_gen;

  logic pixel_clk = 1'b0;
  logic reset_n   = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  int checks = 0, errors = 0, cyc = 0;
  bit mon_en = 1'b0;
  int d_bad = 0, a_bad = 0, s_bad = 0;
  int s_fs_cnt = 0, s_ls_cnt = 0, d_ls_cnt = 0;

  // default 640x480 build
  logic d_hs, d_vs, d_an, d_sync, d_ls, d_fs, d_vb, d_vpa;
  logic [9:0] d_x, d_y;
  logic [7:0] d_vpx, d_vpy;
  // alternate build: 320 wide, HS active-high, SCALE 2 at x=0
  logic a_hs, a_vs, a_an, a_sync, a_ls, a_fs, a_vb, a_vpa;
  logic [8:0] a_x;
  logic [4:0] a_y;
  logic [7:0] a_vpx;
  logic [2:0] a_vpy;
  // tiny build: 24x13 raster, SCALE 1
  logic s_hs, s_vs, s_an, s_sync, s_ls, s_fs, s_vb, s_vpa;
  logic [4:0] s_x;
  logic [3:0] s_y;
  logic [1:0] s_vpx, s_vpy;

  video_timing_gen u_dut (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .hs(d_hs), .vs(d_vs),
    .active_nblank(d_an), .sync(d_sync), .drawX(d_x), .drawY(d_y),
    .line_start(d_ls), .frame_start(d_fs), .vblank_start(d_vb),
    .vp_active(d_vpa), .vp_x(d_vpx), .vp_y(d_vpy)
  );

  video_timing_gen #(
    .H_ACTIVE(320), .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VP_X0(0), .VP_Y0(2), .VP_H(8), .SCALE(2)
  ) u_alt (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .hs(a_hs), .vs(a_vs),
    .active_nblank(a_an), .sync(a_sync), .drawX(a_x), .drawY(a_y),
    .line_start(a_ls), .frame_start(a_fs), .vblank_start(a_vb),
    .vp_active(a_vpa), .vp_x(a_vpx), .vp_y(a_vpy)
  );

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(1),
    .VP_X0(2), .VP_Y0(1), .VP_W(4), .VP_H(3), .SCALE(1)
  ) u_small (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .hs(s_hs), .vs(s_vs),
    .active_nblank(s_an), .sync(s_sync), .drawX(s_x), .drawY(s_y),
    .line_start(s_ls), .frame_start(s_fs), .vblank_start(s_vb),
    .vp_active(s_vpa), .vp_x(s_vpx), .vp_y(s_vpy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Arithmetic reference for every output of all three builds at pixel p = cyc-1.
  task automatic monitor();
    int p, x, y;
    bit vpa, vyin;
    logic [42:0] d_e;
    logic [32:0] a_e;
    logic [23:0] s_e;
    p = cyc - 1;

    x = p % 800; y = (p / 800) % 525;
    vpa  = (x >= 80 && x < 560 && y >= 24 && y < 456);
    vyin = (y >= 24 && y < 456);
    d_e = {!(x >= 656 && x < 752), !(y >= 490 && y < 492), (x < 640 && y < 480),
           x == 0, (x == 0 && y == 0), (x == 0 && y == 480), vpa,
           10'(x), 10'(y), 8'(vpa ? (x - 80) / 3 : 0), 8'(vyin ? (y - 24) / 3 : 0)};
    if ({d_hs, d_vs, d_an, d_ls, d_fs, d_vb, d_vpa, d_x, d_y, d_vpx, d_vpy} !== d_e) d_bad++;

    x = p % 480; y = (p / 480) % 26;
    vyin = (y >= 2 && y < 18);
    vpa  = (x < 320 && vyin);
    a_e = {(x >= 336 && x < 432), !(y >= 22 && y < 24), (x < 320 && y < 20),
           x == 0, (x == 0 && y == 0), (x == 0 && y == 20), vpa,
           9'(x), 5'(y), 8'(vpa ? x / 2 : 0), 3'(vyin ? (y - 2) / 2 : 0)};
    if ({a_hs, a_vs, a_an, a_ls, a_fs, a_vb, a_vpa, a_x, a_y, a_vpx, a_vpy} !== a_e) a_bad++;

    x = p % 24; y = (p / 24) % 13;
    vyin = (y >= 1 && y < 4);
    vpa  = (x >= 2 && x < 6 && vyin);
    s_e = {!(x >= 18 && x < 21), !(y >= 10 && y < 12), (x < 16 && y < 8),
           x == 0, (x == 0 && y == 0), (x == 0 && y == 8), vpa,
           5'(x), 4'(y), 2'(vpa ? x - 2 : 0), 2'(vyin ? y - 1 : 0)};
    if ({s_hs, s_vs, s_an, s_ls, s_fs, s_vb, s_vpa, s_x, s_y, s_vpx, s_vpy} !== s_e) s_bad++;

    if (s_fs) s_fs_cnt++;
    if (s_ls) s_ls_cnt++;
    if (d_ls) d_ls_cnt++;
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
    cyc++;
    if (mon_en) monitor();
  endtask

  task automatic goto(input int p);
    while (cyc < p + 1) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (5) @(posedge pixel_clk);
    #1;
    chk("rst_hs", d_hs, 1);       chk("rst_vs", d_vs, 1);
    chk("rst_an", d_an, 0);       chk("rst_x", d_x, 0);
    chk("rst_y", d_y, 0);         chk("rst_fs", d_fs, 0);
    chk("rst_ls", d_ls, 0);       chk("rst_vpa", d_vpa, 0);
    chk("rst_alt_hs", a_hs, 0);   chk("sync_d", d_sync, 0);
    chk("sync_a", a_sync, 0);     chk("sync_s", s_sync, 0);

    #4 reset_n = 1'b1;
    cyc = 0;
    mon_en = 1'b1;
    tick();
    chk("first_x", d_x, 0);       chk("first_y", d_y, 0);
    chk("first_fs", d_fs, 1);     chk("first_ls", d_ls, 1);
    chk("first_an", d_an, 1);     chk("first_alt_fs", a_fs, 1);
    chk("first_small_fs", s_fs, 1);
    tick();
    chk("second_x", d_x, 1);      chk("second_fs", d_fs, 0);
    chk("second_ls", d_ls, 0);

    goto(17);  chk("s_hs_pre", s_hs, 1);
    goto(18);  chk("s_hs_beg", s_hs, 0);
    goto(20);  chk("s_hs_last", s_hs, 0);
    goto(21);  chk("s_hs_post", s_hs, 1);
    goto(26);  chk("s_vpa_beg", s_vpa, 1); chk("s_vpx_beg", s_vpx, 0); chk("s_vpy_r1", s_vpy, 0);
    goto(29);  chk("s_vpx_last", s_vpx, 3);
    goto(30);  chk("s_vpa_end", s_vpa, 0); chk("s_vpx_end", s_vpx, 0);
    goto(76);  chk("s_vpx_r3", s_vpx, 2);  chk("s_vpy_r3", s_vpy, 2);
    goto(98);  chk("s_vpa_r4", s_vpa, 0);  chk("s_vpy_r4", s_vpy, 0);
    goto(192); chk("s_vblank", s_vb, 1);   chk("s_an_vb", s_an, 0); chk("s_y_vb", s_y, 8);
    goto(239); chk("s_vs_pre", s_vs, 1);
    goto(240); chk("s_vs_beg", s_vs, 0);
    goto(287); chk("s_vs_last", s_vs, 0);
    goto(288); chk("s_vs_post", s_vs, 1);
    goto(311); chk("s_wrap_x", s_x, 23);   chk("s_wrap_y", s_y, 12); chk("s_wrap_fs0", s_fs, 0);
    goto(312); chk("s_wrap_fs", s_fs, 1);  chk("s_wrap_ls", s_ls, 1);
    chk("s_wrap_x0", s_x, 0);  chk("s_wrap_y0", s_y, 0);
    chk("s_fs_count", s_fs_cnt, 2);        chk("s_ls_count", s_ls_cnt, 14);
    goto(313); chk("s_fs_after", s_fs, 0);

    goto(335); chk("a_hs_pre", a_hs, 0);
    goto(336); chk("a_hs_beg", a_hs, 1);
    goto(480); chk("a_ls", a_ls, 1);       chk("a_x_l1", a_x, 0); chk("a_y_l1", a_y, 1);

    goto(639); chk("d_an_639", d_an, 1);
    goto(640); chk("d_an_640", d_an, 0);
    goto(655); chk("d_hs_655", d_hs, 1);
    goto(656); chk("d_hs_656", d_hs, 0);
    goto(751); chk("d_hs_751", d_hs, 0);
    goto(752); chk("d_hs_752", d_hs, 1);
    goto(800); chk("d_ls_800", d_ls, 1);   chk("d_x_800", d_x, 0); chk("d_y_800", d_y, 1);

    goto(960);  chk("a_vpa_r2", a_vpa, 1); chk("a_vpx_0", a_vpx, 0); chk("a_vpy_r2", a_vpy, 0);
    goto(961);  chk("a_vpx_1", a_vpx, 0);
    goto(962);  chk("a_vpx_2", a_vpx, 1);
    goto(1279); chk("a_vpx_319", a_vpx, 159);
    goto(1280); chk("a_vpa_320", a_vpa, 0); chk("a_vpx_320", a_vpx, 0);
    goto(1440); chk("a_vpy_r3", a_vpy, 0);
    goto(1600); chk("d_ls_count", d_ls_cnt, 3);
    goto(1920); chk("a_vpy_r4", a_vpy, 1);
    goto(7685); chk("a_vpy_r16", a_vpy, 7); chk("a_vpx_r16", a_vpx, 2);
    goto(8640); chk("a_vpa_r18", a_vpa, 0); chk("a_vpy_r18", a_vpy, 0);

    goto(19279); chk("d_vpa_79", d_vpa, 0);
    goto(19280); chk("d_vpa_80", d_vpa, 1); chk("d_vpx_80", d_vpx, 0); chk("d_vpy_24", d_vpy, 0);
    goto(19282); chk("d_vpx_82", d_vpx, 0);
    goto(19283); chk("d_vpx_83", d_vpx, 1);
    goto(19759); chk("d_vpx_559", d_vpx, 159); chk("d_vpa_559", d_vpa, 1);
    goto(19760); chk("d_vpa_560", d_vpa, 0); chk("d_vpx_560", d_vpx, 0);
    goto(20900); chk("d_vpy_26", d_vpy, 0);  chk("d_vpx_100", d_vpx, 6);
    goto(21700); chk("d_vpy_27", d_vpy, 1);
    goto(22000); chk("d_x_mid", d_x, 400);   chk("d_y_mid", d_y, 27);

    chk("d_raster_mismatches", d_bad, 0);
    chk("a_raster_mismatches", a_bad, 0);
    chk("s_raster_mismatches", s_bad, 0);

    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_x", d_x, 0);      chk("mid_y", d_y, 0);
    chk("mid_hs", d_hs, 1);    chk("mid_an", d_an, 0);
    chk("mid_vpa", d_vpa, 0);  chk("mid_vpx", d_vpx, 0);
    chk("mid_vpy", d_vpy, 0);  chk("mid_alt_hs", a_hs, 0);
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    reset_n = 1'b1;
    cyc = 0;
    tick();
    chk("restart_x", d_x, 0);  chk("restart_y", d_y, 0);
    chk("restart_fs", d_fs, 1); chk("restart_an", d_an, 1);
    tick();
    chk("restart_x1", d_x, 1); chk("restart_fs1", d_fs, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
